ram_copy_engine: RTL and testbench

- Initiator-side sequencer that drives the RAM64 port (address, in, load, out) as the requesting end of the memory interface.
- Performs either a block copy (read word from src, write to dst) or a block fill (constant to dst) over a programmable length.
- Used for memory initialisation, screen clearing and bench preload in the computer top level.
- Sits between control logic and the data RAM mux; owns the RAM port only while busy.

---
 rtl/ram_copy_engine.sv | 146 ++++++++++++++
 tb/tb_ram_copy_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_copy_engine.sv
// Block copy / block fill sequencer that owns the RAM64 port while busy.
// Copy takes READ then WRITE per word; fill issues one WRITE per word.
module ram_copy_engine #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fill_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_src_ptr;
  logic [ADDR_W-1:0]   r_dst_ptr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_fill_mode;
  logic [DATA_W-1:0]   r_fill_value;
  logic [DATA_W-1:0]   r_data;
  logic                w_last_word;

  assign w_last_word = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});

  // State register; reset forces IDLE so mem_load drops without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_next_state = S_DONE;
          end else if (fill_mode) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_READ;
          end
        end
      end
      S_READ: begin
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (w_last_word) begin
          w_next_state = S_DONE;
        end else if (r_fill_mode) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_READ;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operation registers: loaded once at start, then stepped by each WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_remaining  <= '0;
      r_fill_mode  <= 1'b0;
      r_fill_value <= '0;
      r_data       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_ptr    <= src_addr;
            r_dst_ptr    <= dst_addr;
            r_remaining  <= len;
            r_fill_mode  <= fill_mode;
            r_fill_value <= fill_value;
          end
        end
        S_READ: begin
          r_data <= mem_out;
        end
        S_WRITE: begin
          r_src_ptr   <= r_src_ptr + 1'b1;
          r_dst_ptr   <= r_dst_ptr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs: nothing here depends on start, so the RAM port never sees it directly.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    unique case (r_state)
      S_READ: begin
        busy        = 1'b1;
        mem_address = r_src_ptr;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_address = r_dst_ptr;
        mem_load    = 1'b1;
        mem_in      = r_fill_mode ? r_fill_value : r_data;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a behavioural 64x16 RAM on the port.
// Each task drives one scenario and compares against hand-computed values.
module tb_ram_copy_engine;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        fill_mode;
  logic [5:0]  src_addr;
  logic [5:0]  dst_addr;
  logic [6:0]  len;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [5:0]  mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  logic [15:0] ram [64];
  logic        pl_en;
  logic        pl_clr;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  int n_pass;
  int n_total;

  int busy_cnt;
  int load_cnt;
  int done_cnt;
  int done_cycle;
  int log_addr [128];

  ram_copy_engine #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .fill_mode  (fill_mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_load   (mem_load),
    .mem_out    (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge; bench preload shares the write port.
  assign mem_out = ram[mem_address];
  always @(posedge clk) begin
    if (mem_load) begin
      ram[mem_address] <= mem_in;
    end else if (pl_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= 16'h0000;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end
  end

  task automatic ram_clear();
    @(negedge clk);
    pl_clr = 1'b1;
    @(posedge clk);
    #1 pl_clr = 1'b0;
  endtask

  task automatic ram_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Launches one operation and records per-cycle activity; cycle 1 is the cycle after the start edge.
  task automatic run_op(input logic fm, input logic [5:0] s, input logic [5:0] d,
                        input logic [6:0] l, input logic [15:0] fv, input int inj);
    bit stop;
    @(negedge clk);
    fill_mode = fm; src_addr = s; dst_addr = d; len = l; fill_value = fv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0; load_cnt = 0; done_cnt = 0; done_cycle = 0; stop = 1'b0;
    for (int k = 1; k <= 300 && !stop; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_load) begin
        if (load_cnt < 128) log_addr[load_cnt] = int'(mem_address);
        load_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cycle == 0) done_cycle = k;
      end
      if (done_cycle != 0 && k >= done_cycle + 2) stop = 1'b1;
      if (inj != 0 && k == inj) begin
        start = 1'b1; dst_addr = 6'd40; fill_mode = 1'b1; fill_value = 16'hDEAD; len = 7'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_load !== 1'b0 || mem_address !== 6'd0 || mem_in !== 16'd0)
      $display("FAIL reset_outputs: busy=%b done=%b load=%b addr=%0d in=%h, required all zero",
               busy, done, mem_load, mem_address, mem_in);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_load !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b load=%b, required 0 0 0", busy, done, mem_load);
    else n_pass++;
    $display("test_reset: outputs checked during and after reset");
  endtask

  task automatic test_copy();
    logic [15:0] src_words [4];
    src_words[0] = 16'h1111; src_words[1] = 16'h2222; src_words[2] = 16'h3333; src_words[3] = 16'h4444;
    ram_clear();
    for (int i = 0; i < 4; i++) ram_write(6'(i), src_words[i]);
    run_op(1'b0, 6'd0, 6'd10, 7'd4, 16'h0000, 0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (ram[10 + i] !== src_words[i])
        $display("FAIL copy_dst[%0d]: got %h, required %h", 10 + i, ram[10 + i], src_words[i]);
      else n_pass++;
      n_total++;
      if (ram[i] !== src_words[i])
        $display("FAIL copy_src[%0d]: got %h, required %h", i, ram[i], src_words[i]);
      else n_pass++;
    end
    n_total++;
    if (busy_cnt != 8) $display("FAIL copy_busy_cycles: got %0d, required 8", busy_cnt); else n_pass++;
    n_total++;
    if (done_cycle != 9) $display("FAIL copy_done_cycle: got %0d, required 9", done_cycle); else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL copy_done_pulses: got %0d, required 1", done_cnt); else n_pass++;
    n_total++;
    if (load_cnt != 4) $display("FAIL copy_load_cycles: got %0d, required 4", load_cnt); else n_pass++;
    $display("test_copy: src=0 dst=10 len=4 busy=%0d loads=%0d done@%0d", busy_cnt, load_cnt, done_cycle);
  endtask

  task automatic test_fill_wrap();
    int exp_addr [4];
    exp_addr[0] = 62; exp_addr[1] = 63; exp_addr[2] = 0; exp_addr[3] = 1;
    ram_clear();
    ram_write(6'd2, 16'h1234);
    run_op(1'b1, 6'd0, 6'd62, 7'd4, 16'hBEEF, 0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (ram[exp_addr[i]] !== 16'hBEEF)
        $display("FAIL fill_word[%0d]: got %h, required beef", exp_addr[i], ram[exp_addr[i]]);
      else n_pass++;
      n_total++;
      if (log_addr[i] != exp_addr[i])
        $display("FAIL fill_order[%0d]: got addr %0d, required %0d", i, log_addr[i], exp_addr[i]);
      else n_pass++;
    end
    n_total++;
    if (ram[2] !== 16'h1234) $display("FAIL fill_untouched[2]: got %h, required 1234", ram[2]); else n_pass++;
    n_total++;
    if (load_cnt != 4) $display("FAIL fill_load_cycles: got %0d, required 4", load_cnt); else n_pass++;
    n_total++;
    if (done_cycle != 5) $display("FAIL fill_done_cycle: got %0d, required 5", done_cycle); else n_pass++;
    $display("test_fill_wrap: dst=62 len=4 loads=%0d done@%0d", load_cnt, done_cycle);
  endtask

  task automatic test_zero_length();
    run_op(1'b0, 6'd0, 6'd50, 7'd0, 16'h0000, 0);
    n_total++;
    if (load_cnt != 0) $display("FAIL zero_loads: got %0d, required 0", load_cnt); else n_pass++;
    n_total++;
    if (busy_cnt != 0) $display("FAIL zero_busy: got %0d, required 0", busy_cnt); else n_pass++;
    n_total++;
    if (done_cycle != 1) $display("FAIL zero_done_cycle: got %0d, required 1", done_cycle); else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL zero_done_pulses: got %0d, required 1", done_cnt); else n_pass++;
    $display("test_zero_length: loads=%0d busy=%0d done@%0d", load_cnt, busy_cnt, done_cycle);
  endtask

  task automatic test_overlap();
    ram_write(6'd5, 16'hA5A5);
    ram_write(6'd6, 16'h0001);
    ram_write(6'd7, 16'h0002);
    ram_write(6'd9, 16'h0009);
    run_op(1'b0, 6'd5, 6'd6, 7'd3, 16'h0000, 0);
    for (int i = 5; i <= 8; i++) begin
      n_total++;
      if (ram[i] !== 16'hA5A5) $display("FAIL overlap_word[%0d]: got %h, required a5a5", i, ram[i]);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (log_addr[i] != 6 + i)
        $display("FAIL overlap_order[%0d]: got addr %0d, required %0d", i, log_addr[i], 6 + i);
      else n_pass++;
    end
    n_total++;
    if (ram[9] !== 16'h0009) $display("FAIL overlap_untouched[9]: got %h, required 0009", ram[9]); else n_pass++;
    $display("test_overlap: src=5 dst=6 len=3 loads=%0d", load_cnt);
  endtask

  task automatic test_start_while_busy();
    ram_write(6'd20, 16'hC001);
    ram_write(6'd21, 16'hC002);
    ram_write(6'd22, 16'hC003);
    run_op(1'b0, 6'd20, 6'd30, 7'd3, 16'h0000, 2);
    n_total++;
    if (ram[40] !== 16'h0000) $display("FAIL busy_start_ignored: ram[40]=%h, required 0000", ram[40]); else n_pass++;
    n_total++;
    if (ram[30] !== 16'hC001 || ram[31] !== 16'hC002 || ram[32] !== 16'hC003)
      $display("FAIL busy_copy_data: got %h %h %h, required c001 c002 c003", ram[30], ram[31], ram[32]);
    else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL busy_done_pulses: got %0d, required 1", done_cnt); else n_pass++;
    n_total++;
    if (done_cycle != 7) $display("FAIL busy_done_cycle: got %0d, required 7", done_cycle); else n_pass++;
    n_total++;
    if (load_cnt != 3) $display("FAIL busy_load_cycles: got %0d, required 3", load_cnt); else n_pass++;
    run_op(1'b1, 6'd0, 6'd40, 7'd1, 16'h7777, 0);
    n_total++;
    if (ram[40] !== 16'h7777) $display("FAIL restart_accepted: ram[40]=%h, required 7777", ram[40]); else n_pass++;
    n_total++;
    if (done_cycle != 2) $display("FAIL restart_done_cycle: got %0d, required 2", done_cycle); else n_pass++;
    $display("test_start_while_busy: done@%0d ram[40]=%h", done_cycle, ram[40]);
  endtask

  task automatic test_reset_mid_op();
    ram_clear();
    @(negedge clk);
    fill_mode = 1'b1; dst_addr = 6'd0; src_addr = 6'd0; len = 7'd64; fill_value = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    n_total++;
    if (mem_load !== 1'b1 || mem_address !== 6'd9)
      $display("FAIL midop_write10: load=%b addr=%0d, required 1 9", mem_load, mem_address);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (mem_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midop_async_drop: load=%b busy=%b done=%b, required 0 0 0", mem_load, busy, done);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      n_total++;
      if (ram[i] !== 16'hFFFF) $display("FAIL midop_written[%0d]: got %h, required ffff", i, ram[i]);
      else n_pass++;
    end
    n_total++;
    if (ram[9] !== 16'h0000 || ram[10] !== 16'h0000 || ram[63] !== 16'h0000)
      $display("FAIL midop_unwritten: ram9=%h ram10=%h ram63=%h, required 0000", ram[9], ram[10], ram[63]);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || mem_load !== 1'b0 || done !== 1'b0)
      $display("FAIL midop_idle_after: busy=%b load=%b done=%b, required 0 0 0", busy, mem_load, done);
    else n_pass++;
    $display("test_reset_mid_op: reset during 10th write, engine idle after release");
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; start = 1'b0; fill_mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_value = '0;
    pl_en = 1'b0; pl_clr = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_zero_length();
    test_overlap();
    test_start_while_busy();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
